count_seq_checker: RTL
======================

# count_seq_checker

Receive-side companion to the free-running up-counter. It samples the counter's output bus and checks that every sample is the previous value plus one, modulo 2^WIDTH. It acquires lock on the sequence, reports mismatches, counts wrap-arounds and drops lock after persistent faults. It sits downstream of a COUNTER instance, in hardware or in a bench, as a self-checking monitor.

## Interface
Parameters:
- WIDTH, 4: width of the monitored count.
- SYNC_LEN, 2: number of consecutive correct increments required to declare lock (≥1).
- LOSS_LEN, 3: number of consecutive mismatches while locked that drop lock (≥1).
- ALLOW_STALL, 1: when 1, a sample equal to the previous sample is a stall, not an error.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- cnt_in, input, WIDTH: sampled count value.
- cnt_valid, input, 1: cnt_in is a sample this cycle.
- clr_err, input, 1: synchronous clear of err, err_count and wrap_count.
- locked, output, 1: high while in state LOCK.
- mismatch, output, 1: one-cycle pulse per mismatching sample while locked.
- err, output, 1: sticky; set by any mismatch.
- err_count, output, 8: saturating mismatch count; holds at 255.
- wrap_count, output, 8: saturating count of locked (2^WIDTH−1)→0 transitions; holds at 255.
- expected, output, WIDTH: the next expected value, last+1 mod 2^WIDTH; reads 0 in HUNT.

## Operation
- Internal state: `last` (the previous sample, WIDTH bits), good_run, bad_run, and the FSM {HUNT, SYNC, LOCK}.
- Sample classes, relative to `last`:
  - ok: s == last+1 mod 2^WIDTH.
  - stall: s == last and ALLOW_STALL = 1.
  - bad: anything else.
- Cycles with cnt_valid = 0 change nothing; mismatch is 0 in those cycles.
- HUNT:
  - On a valid sample: last ← s, good_run ← 0, go to SYNC.
- SYNC (last ← s on every sample):
  - ok: good_run++. Enter LOCK when good_run reaches SYNC_LEN; bad_run ← 0 on entry.
  - stall: no change to good_run.
  - bad: good_run ← 0; stay in SYNC.
  - No errors are counted in SYNC.
- LOCK (last ← s on every sample, so the checker re-anchors after an error):
  - ok: bad_run ← 0. If s == 0, wrap_count++ (saturating).
  - stall: no counter changes; bad_run is unchanged.
  - bad: mismatch pulses, err ← 1, err_count++ (saturating), bad_run++. When bad_run reaches LOSS_LEN, go to HUNT.
- Arithmetic and saturation:
  - Increment comparison wraps: the sample after 2^WIDTH−1 must be 0.
  - Both 8-bit counters saturate at 255 and never wrap.
- clr_err:
  - Clears err, err_count and wrap_count. It does not affect the FSM, `last` or the run counters.
  - If an increment event occurs in the same cycle, clr_err wins: the result is 0 and the event is dropped.
  - The mismatch pulse still fires.
- rst:
  - Forces HUNT and clears `last`, the run counters and every output to 0.
  - Overrides cnt_valid and clr_err.

## Timing
- All outputs are registered. An effect of a sample presented at edge N is visible after edge N (one-cycle latency).
- locked rises in the cycle after the SYNC_LEN-th ok sample in SYNC.
- locked falls in the cycle after the LOSS_LEN-th consecutive bad sample. The mismatch pulse for that sample is in the same cycle.
- mismatch is exactly one cycle wide per bad sample. Back-to-back bad samples give back-to-back pulses.
- Reset values: locked = 0, mismatch = 0, err = 0, err_count = 0, wrap_count = 0, expected = 0.
- rst asserted mid-lock: all outputs are 0 one cycle later. The first valid sample after rst drops is the HUNT anchor.
- expected updates in the cycle after each valid sample. It holds otherwise.

## Test plan
All scenarios use the defaults: WIDTH = 4, SYNC_LEN = 2, LOSS_LEN = 3, ALLOW_STALL = 1.

1. Acquire lock and count a wrap.
   - Stimulus: rst for 2 cycles, then valid samples 0,1,2,…,15,0,1.
   - Response: locked = 1 the cycle after sample 2; expected = 3 after sample 2; wrap_count = 1 after sample 15→0; err = 0, err_count = 0.
2. Single glitch while locked.
   - Stimulus: lock, then 3,5,6,7.
   - Response: one mismatch pulse, at 5; err_count = 1, err = 1; locked stays 1; no pulse at 6 or 7.
3. Loss of lock.
   - Stimulus: lock, then 3,9,2,12.
   - Response: mismatch pulses at 9, 2 and 12; err_count = 3; locked = 0 the cycle after 12; expected = 0.
4. Stall handling.
   - Stimulus: lock, then 4,4,4,5 (counter held in reset gives repeated 0s similarly); repeat with ALLOW_STALL = 0.
   - Response: no mismatch and locked = 1 in the first run. With ALLOW_STALL = 0: two mismatches, and the final 5 is ok.
5. Saturation and clear.
   - Stimulus: drive 300 alternating bad samples with LOSS_LEN = 255 to stay locked; then assert clr_err in the same cycle as a bad sample.
   - Response: err_count holds at 255; after the clear, err_count = 0 and err = 0; the mismatch pulse is still seen.
6. Reset mid-operation.
   - Stimulus: lock with err_count = 2, then assert rst for 1 cycle while cnt_valid = 1.
   - Response: the next cycle has all outputs 0; after rst falls, relock occurs after 3 valid samples.

Source files
------------

// File: rtl/count_seq_checker.sv
// Receive-side monitor for a free-running up-counter: acquires lock on the
// +1 sequence, flags mismatches, counts wraps and drops lock on persistent faults.
module count_seq_checker #(
    parameter int WIDTH       = 4,
    parameter int SYNC_LEN    = 2,
    parameter int LOSS_LEN    = 3,
    parameter int ALLOW_STALL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_valid,
    input  logic             clr_err,
    output logic             locked,
    output logic             mismatch,
    output logic             err,
    output logic [7:0]       err_count,
    output logic [7:0]       wrap_count,
    output logic [WIDTH-1:0] expected
);

    typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_e;

    localparam int GW = $clog2(SYNC_LEN + 1);
    localparam int BW = $clog2(LOSS_LEN + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [GW-1:0]    good_run_q, good_run_d;
    logic [BW-1:0]    bad_run_q, bad_run_d;
    logic             locked_q, locked_d;
    logic             mismatch_q, mismatch_d;
    logic             err_q, err_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [7:0]       wrap_count_q, wrap_count_d;
    logic [WIDTH-1:0] expected_q, expected_d;

    logic [WIDTH-1:0] last_inc;
    logic             s_ok, s_stall, s_bad;

    assign last_inc = last_q + WIDTH'(1);
    assign s_ok     = (cnt_in == last_inc);
    assign s_stall  = !s_ok && (cnt_in == last_q) && (ALLOW_STALL != 0);
    assign s_bad    = !s_ok && !s_stall;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            last_q       <= '0;
            good_run_q   <= '0;
            bad_run_q    <= '0;
            locked_q     <= 1'b0;
            mismatch_q   <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
            expected_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            locked_q     <= locked_d;
            mismatch_q   <= mismatch_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
            expected_q   <= expected_d;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        if (cnt_valid) begin
            unique case (state_q)
                HUNT: begin
                    good_run_d = '0;
                    state_d    = SYNC;
                end
                SYNC: begin
                    if (s_ok) begin
                        good_run_d = good_run_q + GW'(1);
                        if (good_run_d == GW'(SYNC_LEN)) begin
                            state_d   = LOCK;
                            bad_run_d = '0;
                        end
                    end else if (s_bad) begin
                        good_run_d = '0;
                    end
                end
                LOCK: begin
                    if (s_ok) begin
                        bad_run_d = '0;
                    end else if (s_bad) begin
                        bad_run_d = bad_run_q + BW'(1);
                        if (bad_run_d == BW'(LOSS_LEN)) state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        last_d       = last_q;
        mismatch_d   = 1'b0;
        err_d        = err_q;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;
        expected_d   = expected_q;
        locked_d     = (state_d == LOCK);
        if (cnt_valid) begin
            last_d     = cnt_in;
            expected_d = (state_d == HUNT) ? '0 : cnt_in + WIDTH'(1);
            if (state_q == LOCK) begin
                if (s_bad) begin
                    mismatch_d = 1'b1;
                    err_d      = 1'b1;
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                end else if (s_ok && cnt_in == '0 && wrap_count_q != 8'hFF) begin
                    wrap_count_d = wrap_count_q + 8'd1;
                end
            end
        end
        // A clear in the same cycle as an increment wins; the mismatch pulse is kept.
        if (clr_err) begin
            err_d        = 1'b0;
            err_count_d  = '0;
            wrap_count_d = '0;
        end
    end

    assign locked     = locked_q;
    assign mismatch   = mismatch_q;
    assign err        = err_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;
    assign expected   = expected_q;

endmodule
